// File: rtl/modexp_ctrl_if.sv
// Request/result handshake bundle between the RSA front end and modexp_ctrl.
// master = front end (issues requests, consumes results), slave = modexp_ctrl.
interface modexp_ctrl_if #(
  parameter int BIT  = 8,
  parameter int EBIT = 8
);
  logic            req_valid;
  logic            req_ready;
  logic [BIT-1:0]  base;
  logic [EBIT-1:0] exp;
  logic [BIT-1:0]  modn;
  logic            res_valid;
  logic            res_ready;
  logic [BIT-1:0]  result;
  logic            err;

  modport master (
    output req_valid, base, exp, modn, res_ready,
    input  req_ready, res_valid, result, err
  );

  modport slave (
    input  req_valid, base, exp, modn, res_ready,
    output req_ready, res_valid, result, err
  );
endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing base^exp mod modn,
// time-sharing one external shift-subtract Modulo unit for every reduction.
module modexp_ctrl #(
  parameter int BIT  = 8,
  parameter int EBIT = 8,
  parameter int WDOG = 4
) (
  input  logic             clk,
  input  logic             rst,
  modexp_ctrl_if.slave     bus,
  output logic             mod_start,
  input  logic             mod_busy,
  output logic [BIT-1:0]   mod_c,
  output logic [BIT:0]     mod_hreg,
  output logic [BIT-1:0]   mod_lreg,
  input  logic [BIT-1:0]   mod_m
);

  localparam int IW = $clog2(EBIT) + 1;
  localparam int WW = $clog2(WDOG + 1);
  localparam logic PH_SQ = 1'b0;
  localparam logic PH_ML = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL    = 3'd1,
    S_MSTART = 3'd2,
    S_MWAIT  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e           state_r, state_nxt_s;
  logic             fail_s;

  logic [BIT-1:0]   b_r, b_nxt_s;
  logic [BIT-1:0]   n_r, n_nxt_s;
  logic [BIT-1:0]   r_r, r_nxt_s;
  logic [EBIT-1:0]  e_r, e_nxt_s;
  logic [2*BIT-1:0] p_r, p_nxt_s;
  logic [IW-1:0]    idx_r, idx_nxt_s;
  logic             phase_r, phase_nxt_s;
  logic [WW-1:0]    wdog_r, wdog_nxt_s;

  logic             req_ready_r, req_ready_nxt_s;
  logic             res_valid_r, res_valid_nxt_s;
  logic             mod_start_r, mod_start_nxt_s;
  logic             err_r, err_nxt_s;
  logic [BIT-1:0]   result_r, result_nxt_s;

  logic             bad_s, unit_s, ebit_s, last_s, wdog_exp_s;
  logic [2*BIT-1:0] mul_a_s, mul_b_s;

  // Operand screening: modulus 0 or base not below modulus cannot be reduced in one pass.
  assign bad_s      = (bus.modn == {BIT{1'b0}}) || (bus.base >= bus.modn);
  assign unit_s     = (bus.modn == {{(BIT-1){1'b0}}, 1'b1});
  assign ebit_s     = e_r[idx_r[IW-2:0]];
  assign last_s     = (idx_r == {IW{1'b0}});
  assign wdog_exp_s = (wdog_r == WW'(WDOG - 1));
  assign mul_a_s    = {{BIT{1'b0}}, r_r};
  assign mul_b_s    = (phase_r == PH_ML) ? {{BIT{1'b0}}, b_r} : {{BIT{1'b0}}, r_r};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision, including which DONE entries are error exits.
  always_comb begin
    state_nxt_s = state_r;
    fail_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bad_s) begin
            state_nxt_s = S_DONE;
            fail_s      = 1'b1;
          end else if (unit_s) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_MUL;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_MUL: state_nxt_s = S_MSTART;
      S_MSTART: begin
        if (mod_busy) begin
          state_nxt_s = S_MWAIT;
        end else if (wdog_exp_s) begin
          state_nxt_s = S_DONE;
          fail_s      = 1'b1;
        end else begin
          state_nxt_s = S_MSTART;
        end
      end
      S_MWAIT: begin
        if (!mod_busy) begin
          if ((phase_r == PH_SQ) && ebit_s) begin
            state_nxt_s = S_MUL;
          end else if (last_s) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_MUL;
          end
        end else begin
          state_nxt_s = S_MWAIT;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Datapath next values: operand capture, product, accumulator, bit walk, watchdog.
  always_comb begin
    b_nxt_s     = b_r;
    e_nxt_s     = e_r;
    n_nxt_s     = n_r;
    r_nxt_s     = r_r;
    p_nxt_s     = p_r;
    idx_nxt_s   = idx_r;
    phase_nxt_s = phase_r;
    wdog_nxt_s  = wdog_r;
    case (state_r)
      S_IDLE: begin
        if (bus.req_valid) begin
          b_nxt_s     = bus.base;
          e_nxt_s     = bus.exp;
          n_nxt_s     = bus.modn;
          r_nxt_s     = (bad_s || unit_s) ? {BIT{1'b0}} : {{(BIT-1){1'b0}}, 1'b1};
          idx_nxt_s   = IW'(EBIT - 1);
          phase_nxt_s = PH_SQ;
        end else begin
          r_nxt_s = r_r;
        end
      end
      S_MUL: begin
        p_nxt_s    = mul_a_s * mul_b_s;
        wdog_nxt_s = {WW{1'b0}};
      end
      S_MSTART: begin
        if (!mod_busy) begin
          wdog_nxt_s = wdog_r + WW'(1);
        end else begin
          wdog_nxt_s = wdog_r;
        end
      end
      S_MWAIT: begin
        // The remainder is taken in the first cycle busy is seen low.
        if (!mod_busy) begin
          r_nxt_s = mod_m;
          if ((phase_r == PH_SQ) && ebit_s) begin
            phase_nxt_s = PH_ML;
          end else if (!last_s) begin
            idx_nxt_s   = idx_r - IW'(1);
            phase_nxt_s = PH_SQ;
          end else begin
            phase_nxt_s = phase_r;
          end
        end else begin
          r_nxt_s = r_r;
        end
      end
      S_DONE:  r_nxt_s = r_r;
      default: r_nxt_s = r_r;
    endcase
  end

  // Output decode from the next state so every port comes straight from a flop.
  always_comb begin
    req_ready_nxt_s = (state_nxt_s == S_IDLE);
    res_valid_nxt_s = (state_nxt_s == S_DONE);
    mod_start_nxt_s = (state_nxt_s == S_MSTART) || (state_nxt_s == S_MWAIT);
    if (state_nxt_s != S_DONE) begin
      err_nxt_s    = 1'b0;
      result_nxt_s = {BIT{1'b0}};
    end else if (state_r == S_DONE) begin
      err_nxt_s    = err_r;
      result_nxt_s = result_r;
    end else begin
      err_nxt_s    = fail_s;
      result_nxt_s = fail_s ? {BIT{1'b0}} : r_nxt_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_r         <= {BIT{1'b0}};
      e_r         <= {EBIT{1'b0}};
      n_r         <= {BIT{1'b0}};
      r_r         <= {BIT{1'b0}};
      p_r         <= {(2*BIT){1'b0}};
      idx_r       <= {IW{1'b0}};
      phase_r     <= PH_SQ;
      wdog_r      <= {WW{1'b0}};
      req_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      mod_start_r <= 1'b0;
      err_r       <= 1'b0;
      result_r    <= {BIT{1'b0}};
    end else begin
      b_r         <= b_nxt_s;
      e_r         <= e_nxt_s;
      n_r         <= n_nxt_s;
      r_r         <= r_nxt_s;
      p_r         <= p_nxt_s;
      idx_r       <= idx_nxt_s;
      phase_r     <= phase_nxt_s;
      wdog_r      <= wdog_nxt_s;
      req_ready_r <= req_ready_nxt_s;
      res_valid_r <= res_valid_nxt_s;
      mod_start_r <= mod_start_nxt_s;
      err_r       <= err_nxt_s;
      result_r    <= result_nxt_s;
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.result    = result_r;
  assign bus.err       = err_r;
  assign mod_start     = mod_start_r;
  assign mod_c         = n_r;
  assign mod_hreg      = {1'b0, p_r[2*BIT-1:BIT]};
  assign mod_lreg      = p_r[BIT-1:0];

  modexp_ctrl_chk #(.BIT(BIT)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .req_ready (req_ready_r),
    .res_valid (res_valid_r),
    .res_ready (bus.res_ready),
    .result    (result_r),
    .err       (err_r),
    .mod_start (mod_start_r),
    .mod_hreg  (mod_hreg),
    .mod_c     (mod_c)
  );

endmodule

// Protocol properties of modexp_ctrl: result hold, idle/done exclusivity,
// Modulo kept cleared outside reductions, and the single-pass precondition.
module modexp_ctrl_chk #(
  parameter int BIT = 8
) (
  input logic           clk,
  input logic           rst,
  input logic           req_ready,
  input logic           res_valid,
  input logic           res_ready,
  input logic [BIT-1:0] result,
  input logic           err,
  input logic           mod_start,
  input logic [BIT:0]   mod_hreg,
  input logic [BIT-1:0] mod_c
);
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (res_valid && !res_ready) |=> (res_valid && $stable(result) && $stable(err)));
  a_excl: assert property (@(posedge clk) disable iff (rst)
    !(req_ready && res_valid));
  a_idle_clear: assert property (@(posedge clk) disable iff (rst)
    (req_ready || res_valid) |-> !mod_start);
  a_single_pass: assert property (@(posedge clk) disable iff (rst)
    mod_start |-> (mod_hreg < {1'b0, mod_c}));
endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Sequencer for RSA modular exponentiation, result = base^exp mod modn. It uses left-to-right square-and-multiply and time-shares one external shift-subtract `Modulo` reduction unit for every reduction. The block forms each 2·BIT-bit product internally, hands it to `Modulo` as a 9/8-bit Hreg/Lreg pair, and collects the remainder. It sits between the RSA key/message front end and the `Modulo` datapath, with a valid/ready request port and a valid/ready result port.

## Interface
- BIT, 8, operand/modulus width; must equal the `Modulo` width
- EBIT, 8, exponent width
- WDOG, 4, maximum cycles to wait for mod_busy to rise after mod_start
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle, accepts request
- base  in  BIT  message/base; sampled on request handshake
- exp  in  EBIT  exponent; sampled on request handshake
- modn  in  BIT  modulus; sampled on request handshake
- res_valid  out  1  result present; held until res_ready
- res_ready  in  1  consumer accepts result
- result  out  BIT  base^exp mod modn (0 when err)
- err  out  1  qualifies result: bad operands or watchdog expiry
- mod_start  out  1  `Modulo` start (low = ready/clear, high = run)
- mod_busy  in  1  `Modulo` busy
- mod_c  out  BIT  modulus to `Modulo` (registered modn)
- mod_hreg  out  BIT+1  {1'b0, product[2·BIT-1:BIT]}
- mod_lreg  out  BIT  product[BIT-1:0]
- mod_m  in  BIT  `Modulo` remainder

## Operation
- Registers: B, E, N (captured operands), R (accumulator, BIT), P (product, 2·BIT), bit index i (log2 EBIT + 1 bits), phase flag (SQ/ML), watchdog counter.
- States:
  - IDLE: req_ready=1. On req_valid, capture operands, then:
    - N==0 or B≥N → DONE with err=1, result=0.
    - N==1 → DONE with result=0.
    - else R=1, i=EBIT-1, phase=SQ → MUL.
    - exp==0 with N≥2 still runs and yields 1.
  - MUL: P = R·R (phase SQ) or R·B (phase ML), full 2·BIT width. mod_start=0. → MSTART.
  - MSTART: mod_start=1, watchdog counts. mod_busy=1 → MWAIT. Watchdog reaches WDOG → DONE with err=1.
  - MWAIT: mod_start=1. On mod_busy=0, R=mod_m, then:
    - phase SQ and E[i]=1 → phase=ML, MUL.
    - otherwise, i==0 → DONE.
    - otherwise, i=i-1, phase=SQ → MUL.
  - DONE: res_valid=1, result=R (or 0 when err). On res_ready → IDLE.
- mod_start is low for at least one full cycle (MUL) between consecutive reductions. This guarantees `Modulo` re-initialises.
- Reduction count per request = EBIT + popcount(exp).
- Invariant: R<N and B<N, so the product high half is < N, which is the precondition for a single-pass `Modulo` reduction.
- Arithmetic is unsigned. There is no reduction of B inside the block; B≥N is rejected.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, res_valid=0, result=0, err=0.
  - mod_start=0, mod_c=0, mod_hreg=0, mod_lreg=0, R=0.
- rst mid-operation: the next cycle is IDLE with mod_start=0, which also clears `Modulo`. Any in-flight result is discarded.
- Request handshake: the cycle with req_valid & req_ready. req_ready drops the following cycle.
- Per reduction: 1 (MUL) + MSTART dwell + MWAIT dwell.
  - MSTART dwell with the 8-bit `Modulo` is 1 cycle.
  - busy stays high 2·BIT+1 cycles, so a reduction takes about 2·BIT+4 cycles.
- Bad-operand requests reach DONE 1 cycle after handshake; res_valid asserts in that cycle.
- res_valid/result/err are stable while res_valid & !res_ready.
- Back-to-back requests: after the res handshake, IDLE is entered next cycle. A new request is accepted no earlier than 1 cycle after the result handshake.
- mod_busy glitch-free is assumed only at clk edges. mod_m is sampled in the first cycle mod_busy is observed low in MWAIT.

## Test plan
- Request base=88, exp=7, modn=187, with real `Modulo` (BIT=8) → result=11, err=0, exactly 11 reductions (11 mod_start rising edges).
- Request base=11, exp=23, modn=187 → result=88. Follow immediately with base=4, exp=13, modn=255 → result=4. Checks back-to-back and the ≥1-cycle mod_start low gap.
- Request exp=0, base=5, modn=7 → result=1. Request modn=1 → result=0 with no mod_start pulse. Request modn=0 → err=1 one cycle after handshake. Request base=200, modn=100 → err=1, result=0.
- Tie mod_busy=0 → err=1 after WDOG MSTART cycles, and mod_start returns low in IDLE.
- Assert rst for 1 cycle mid-MWAIT during 88^7 mod 187 → req_ready=1 and mod_start=0 next cycle. A fresh identical request then yields 11.
- Hold res_ready=0 for 10 cycles after result → res_valid/result stable, req_ready=0. Then assert res_ready → IDLE next cycle.
